// File: rtl/burst_rw_sched.sv
// CAS-to-data scheduler: queues up to DEPTH outstanding read/write CAS commands and
// launches each data burst after its latency, honouring bus occupancy and turnaround.
module burst_rw_sched #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 6,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned TURN  = 2
) (
    input  logic             clock_t,
    input  logic             reset,
    input  logic             cas_rdy,
    input  logic             cas_rw,
    input  logic [TAG_W-1:0] cas_tag,
    input  logic             burst_chop,
    input  logic [CNT_W-1:0] rd_delay,
    input  logic [CNT_W-1:0] wr_delay,
    output logic             cas_full,
    output logic             rw_rdy,
    output logic             rw_dir,
    output logic [TAG_W-1:0] rw_tag,
    output logic             data_valid,
    output logic             rw_done,
    output logic             data_idle,
    output logic [CNT_W-1:0] slip,
    output logic             ovf_err
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam int unsigned TAIL_W  = CNT_W + 1;
    localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

    typedef enum logic [1:0] {StIdle, StWait, StData} state_e;

    state_e state_q, state_d;

    logic             q_dir  [DEPTH];
    logic [TAG_W-1:0] q_tag  [DEPTH];
    logic             q_chop [DEPTH];
    logic [CNT_W-1:0] q_cnt  [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [TAIL_W-1:0] tail_q, tail_d;
    logic              last_dir_q;
    logic [2:0]        beats_q, beats_d;
    logic              rw_rdy_q, rw_rdy_d;
    logic              rw_dir_q, rw_dir_d;
    logic [TAG_W-1:0]  rw_tag_q, rw_tag_d;
    logic              valid_q, valid_d;
    logic              rw_done_q, rw_done_d;
    logic [CNT_W-1:0]  slip_q, slip_d;
    logic              ovf_q, ovf_d;

    logic        full, push, pop, start;
    logic [31:0] base_w, need_w, eff_w, eff_sat, blen;
    logic        eff_clamp;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    // Head launches once its countdown expires and the bus frees up this same edge.
    assign start = (count_q != '0) && (q_cnt[rd_ptr_q] <= CNT_W'(1)) &&
                   ((state_q != StData) || (beats_q == 3'd1));
    assign pop   = start;
    assign push  = cas_rdy && (!full || pop);

    always_comb begin
        base_w = 32'(cas_rw ? wr_delay : rd_delay);
        if (base_w == 32'd0) begin
            base_w = 32'd1;
        end
        need_w = 32'(tail_q);
        if ((tail_q != '0) && (cas_rw != last_dir_q)) begin
            need_w = need_w + 32'(TURN);
        end
        eff_w     = (need_w > base_w) ? need_w : base_w;
        eff_clamp = (eff_w > 32'(CNT_MAX));
        eff_sat   = eff_clamp ? 32'(CNT_MAX) : eff_w;
        blen      = burst_chop ? 32'd2 : 32'd4;
    end

    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
        tail_d  = (tail_q != '0) ? tail_q - 1'b1 : tail_q;
        slip_d  = slip_q;
        if (push) begin
            tail_d = TAIL_W'(eff_sat + blen - 32'd1);
            slip_d = CNT_W'(eff_sat - base_w);
        end
        ovf_d = ovf_q | (cas_rdy && !push) | (push && eff_clamp);
    end

    always_comb begin
        state_d   = state_q;
        beats_d   = beats_q;
        rw_rdy_d  = 1'b0;
        rw_done_d = 1'b0;
        valid_d   = valid_q;
        rw_dir_d  = rw_dir_q;
        rw_tag_d  = rw_tag_q;
        unique case (state_q)
            StIdle: begin
                if (push) begin
                    state_d = StWait;
                end
            end
            StWait: ;
            StData: begin
                if (beats_q == 3'd1) begin
                    rw_done_d = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = (count_d != '0) ? StWait : StIdle;
                end else begin
                    beats_d = beats_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (start) begin
            state_d  = StData;
            beats_d  = q_chop[rd_ptr_q] ? 3'd2 : 3'd4;
            rw_rdy_d = 1'b1;
            valid_d  = 1'b1;
            rw_dir_d = q_dir[rd_ptr_q];
            rw_tag_d = q_tag[rd_ptr_q];
        end
    end

    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            tail_q     <= '0;
            last_dir_q <= 1'b0;
            beats_q    <= '0;
            rw_rdy_q   <= 1'b0;
            rw_dir_q   <= 1'b0;
            rw_tag_q   <= '0;
            valid_q    <= 1'b0;
            rw_done_q  <= 1'b0;
            slip_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tail_q    <= tail_d;
            beats_q   <= beats_d;
            rw_rdy_q  <= rw_rdy_d;
            rw_dir_q  <= rw_dir_d;
            rw_tag_q  <= rw_tag_d;
            valid_q   <= valid_d;
            rw_done_q <= rw_done_d;
            slip_q    <= slip_d;
            ovf_q     <= ovf_d;
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push) begin
                wr_ptr_q   <= ptr_inc(wr_ptr_q);
                last_dir_q <= cas_rw;
            end
        end
    end

    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_dir[i]  <= 1'b0;
                q_tag[i]  <= '0;
                q_chop[i] <= 1'b0;
                q_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_cnt[i] != '0) begin
                    q_cnt[i] <= q_cnt[i] - 1'b1;
                end
            end
            if (push) begin
                q_dir[wr_ptr_q]  <= cas_rw;
                q_tag[wr_ptr_q]  <= cas_tag;
                q_chop[wr_ptr_q] <= burst_chop;
                q_cnt[wr_ptr_q]  <= eff_sat[CNT_W-1:0];
            end
        end
    end

    assign cas_full   = full;
    assign rw_rdy     = rw_rdy_q;
    assign rw_dir     = rw_dir_q;
    assign rw_tag     = rw_tag_q;
    assign data_valid = valid_q;
    assign rw_done    = rw_done_q;
    assign data_idle  = (state_q == StIdle);
    assign slip       = slip_q;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_burst_rw_sched.sv
// Directed bench for burst_rw_sched: latency, back-to-back, turnaround, chop, full and reset.
module tb_burst_rw_sched;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned TURN  = 2;

    logic             clock_t = 1'b0;
    logic             reset = 1'b1;
    logic             cas_rdy = 1'b0;
    logic             cas_rw = 1'b0;
    logic [TAG_W-1:0] cas_tag = '0;
    logic             burst_chop = 1'b0;
    logic [CNT_W-1:0] rd_delay = 6'd11;
    logic [CNT_W-1:0] wr_delay = 6'd9;
    logic             cas_full, rw_rdy, rw_dir, data_valid, rw_done, data_idle, ovf_err;
    logic [TAG_W-1:0] rw_tag;
    logic [CNT_W-1:0] slip;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = -1;
    logic [63:0] rdy_log, valid_log, done_log, idle_log;

    burst_rw_sched #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W),
        .TAG_W(TAG_W),
        .TURN (TURN)
    ) dut (
        .clock_t   (clock_t),
        .reset     (reset),
        .cas_rdy   (cas_rdy),
        .cas_rw    (cas_rw),
        .cas_tag   (cas_tag),
        .burst_chop(burst_chop),
        .rd_delay  (rd_delay),
        .wr_delay  (wr_delay),
        .cas_full  (cas_full),
        .rw_rdy    (rw_rdy),
        .rw_dir    (rw_dir),
        .rw_tag    (rw_tag),
        .data_valid(data_valid),
        .rw_done   (rw_done),
        .data_idle (data_idle),
        .slip      (slip),
        .ovf_err   (ovf_err)
    );

    always #5 clock_t = ~clock_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; cycle index cyc names the edge just taken.
    task automatic step();
        @(posedge clock_t);
        #1;
        cyc++;
        if (cyc >= 0 && cyc < 64) begin
            rdy_log[cyc]   = rw_rdy;
            valid_log[cyc] = data_valid;
            done_log[cyc]  = rw_done;
            idle_log[cyc]  = data_idle;
        end
        cas_rdy = 1'b0;
    endtask

    task automatic cas(input logic rw, input logic [TAG_W-1:0] tag, input logic chop);
        cas_rdy    = 1'b1;
        cas_rw     = rw;
        cas_tag    = tag;
        burst_chop = chop;
        step();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic check_rst(input string pfx);
        check({pfx, "_full"}, 64'(cas_full), 64'd0);
        check({pfx, "_rdy"}, 64'(rw_rdy), 64'd0);
        check({pfx, "_dir"}, 64'(rw_dir), 64'd0);
        check({pfx, "_tag"}, 64'(rw_tag), 64'd0);
        check({pfx, "_valid"}, 64'(data_valid), 64'd0);
        check({pfx, "_done"}, 64'(rw_done), 64'd0);
        check({pfx, "_idle"}, 64'(data_idle), 64'd1);
        check({pfx, "_slip"}, 64'(slip), 64'd0);
        check({pfx, "_ovf"}, 64'(ovf_err), 64'd0);
    endtask

    // Reset is asserted away from any edge and checked before the next one arrives.
    task automatic do_reset(input string pfx);
        reset = 1'b1;
        #1;
        check_rst(pfx);
        @(negedge clock_t);
        reset     = 1'b0;
        cyc       = -1;
        rdy_log   = '0;
        valid_log = '0;
        done_log  = '0;
        idle_log  = '0;
    endtask

    initial begin
        // Single BL8 read, rd_delay 11.
        do_reset("rst0");
        cas(1'b0, 4'd3, 1'b0);
        check("t1_slip", 64'(slip), 64'd0);
        run_to(19);
        check("t1_rdy", rdy_log, 64'h800);
        check("t1_valid", valid_log, 64'h7800);
        check("t1_done", done_log, 64'h8000);
        check("t1_idle", idle_log, 64'hF8000);
        check("t1_tag", 64'(rw_tag), 64'd3);

        // Reads at 0 and 2: second slips by 2.
        do_reset("rst1");
        cas(1'b0, 4'd1, 1'b0);
        step();
        cas(1'b0, 4'd2, 1'b0);
        check("t2a_slip", 64'(slip), 64'd2);
        run_to(15);
        check("t2a_tag15", 64'(rw_tag), 64'd2);
        run_to(20);
        check("t2a_rdy", rdy_log, 64'h8800);
        check("t2a_valid", valid_log, 64'h7F800);
        check("t2a_done", done_log, 64'h88000);

        // Reads at 0 and 4: exactly back-to-back, no slip.
        do_reset("rst2");
        cas(1'b0, 4'd1, 1'b0);
        run_to(3);
        cas(1'b0, 4'd2, 1'b0);
        check("t2b_slip", 64'(slip), 64'd0);
        run_to(20);
        check("t2b_rdy", rdy_log, 64'h8800);
        check("t2b_valid", valid_log, 64'h7F800);

        // Read at 0, write at 4: turnaround pushes write to 17.
        do_reset("rst3");
        cas(1'b0, 4'd5, 1'b0);
        run_to(3);
        cas(1'b1, 4'd9, 1'b0);
        check("t3_slip", 64'(slip), 64'd4);
        run_to(15);
        check("t3_dir15", 64'(rw_dir), 64'd0);
        run_to(17);
        check("t3_dir17", 64'(rw_dir), 64'd1);
        check("t3_tag17", 64'(rw_tag), 64'd9);
        run_to(22);
        check("t3_rdy", rdy_log, 64'h20800);
        check("t3_valid", valid_log, 64'h1E7800);
        check("t3_done", done_log, 64'h208000);

        // BC4 read at 0, BL8 read at 2.
        do_reset("rst4");
        cas(1'b0, 4'd1, 1'b1);
        step();
        cas(1'b0, 4'd2, 1'b0);
        check("t4_slip", 64'(slip), 64'd0);
        run_to(18);
        check("t4_rdy", rdy_log, 64'h2800);
        check("t4_valid", valid_log, 64'h1F800);
        check("t4_done", done_log, 64'h22000);

        // Fill the queue: CAS k at edge k gets eff 11+3k; the 9th is dropped.
        do_reset("rst5");
        for (int i = 0; i < 9; i++) begin
            cas(1'b0, 4'(i), 1'b0);
            if (i == 6) check("t5_full6", 64'(cas_full), 64'd0);
            if (i == 7) begin
                check("t5_full7", 64'(cas_full), 64'd1);
                check("t5_ovf7", 64'(ovf_err), 64'd0);
            end
        end
        check("t5_ovf8", 64'(ovf_err), 64'd1);
        check("t5_slip8", 64'(slip), 64'd21);
        run_to(10);
        check("t5_ovf10", 64'(ovf_err), 64'd1);
        // Write lands on the head pop at 11: need 32+TURN=34, slip 34-9.
        cas(1'b1, 4'd10, 1'b0);
        check("t5_rdy11", 64'(rw_rdy), 64'd1);
        check("t5_full11", 64'(cas_full), 64'd1);
        check("t5_slip11", 64'(slip), 64'd25);
        run_to(15);
        check("t5_full15", 64'(cas_full), 64'd0);
        run_to(39);
        check("t5_rdy39", 64'(rw_rdy), 64'd1);
        check("t5_tag39", 64'(rw_tag), 64'd7);
        run_to(45);
        check("t5_rdy45", 64'(rw_rdy), 64'd1);
        check("t5_dir45", 64'(rw_dir), 64'd1);
        check("t5_tag45", 64'(rw_tag), 64'd10);
        check("t5_ovf45", 64'(ovf_err), 64'd1);

        // Reset in the middle of a burst, then a fresh CAS.
        do_reset("rst6");
        cas(1'b0, 4'd4, 1'b0);
        step();
        cas(1'b0, 4'd6, 1'b0);
        run_to(12);
        check("t6_valid12", 64'(data_valid), 64'd1);
        check("t6_slip12", 64'(slip), 64'd2);
        do_reset("t6_async");
        cas(1'b0, 4'd7, 1'b0);
        check("t6_slip_new", 64'(slip), 64'd0);
        run_to(16);
        check("t6_rdy", rdy_log, 64'h800);

        // Zero read latency behaves as one.
        do_reset("rst7");
        rd_delay = 6'd0;
        cas(1'b0, 4'd8, 1'b0);
        check("t7_slip", 64'(slip), 64'd0);
        run_to(6);
        check("t7_rdy", rdy_log, 64'h2);
        check("t7_valid", valid_log, 64'h1E);
        check("t7_done", done_log, 64'h20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_rw_sched.md
Name: burst_rw_sched

Overview:
Parametrised CAS-to-data scheduler for the DDR4 controller's burst read/write path. It is the multi-outstanding successor of the single-burst RW fsm. It accepts CAS pulses, holds up to DEPTH outstanding read/write commands, and computes each command's effective data start from RD/WR latency, prior bus occupancy and read/write turnaround. It then drives per-burst start, direction, tag and beat-valid signals toward the data path.

Parameters:
DEPTH, 8, maximum outstanding CAS commands held (≥2)
CNT_W, 6, width of latency/countdown counters
TAG_W, 4, width of command tag carried from CAS to data
TURN, 2, extra idle cycles inserted when data direction changes (R→W or W→R)

Ports:
clock_t  in  1  main controller clock (all logic on posedge)
reset  in  1  asynchronous, active-high reset
cas_rdy  in  1  one-cycle pulse: CAS issued this cycle
cas_rw  in  1  CAS direction: 0=READ, 1=WRITE
cas_tag  in  TAG_W  tag of issued CAS
burst_chop  in  1  0=BL8 (4 data clocks), 1=BC4 (2 data clocks); sampled with cas_rdy
rd_delay  in  CNT_W  CAS-to-data latency for reads (RD_DELAY)
wr_delay  in  CNT_W  CAS-to-data latency for writes (WR_DELAY)
cas_full  out  1  queue full; controller must not issue CAS
rw_rdy  out  1  one-cycle pulse: first data clock of a burst
rw_dir  out  1  direction of active burst
rw_tag  out  TAG_W  tag of active burst
data_valid  out  1  high on every data clock of a burst
rw_done  out  1  one-cycle pulse on the clock after a burst's last beat
data_idle  out  1  no burst active and queue empty
slip  out  CNT_W  cycles added beyond base latency for the most recently accepted CAS
ovf_err  out  1  sticky: CAS dropped while full, or countdown saturated

Behaviour:
- Reset (async, high): queue emptied, all counters 0, state IDLE. Outputs: cas_full=0, rw_rdy=0, rw_dir=0, rw_tag=0, data_valid=0, rw_done=0, data_idle=1, slip=0, ovf_err=0. Reset mid-burst abandons all in-flight bursts immediately.
- Accept: cas_rdy=1 at edge t and not full. Entry {dir, tag, B, countdown} is pushed. B=4 (BL8) or 2 (BC4). delay 0 is treated as 1.
- base = cas_rw ? wr_delay : rd_delay.
- need = tail_free, plus TURN if bus is occupied/scheduled and cas_rw ≠ last scheduled direction. Otherwise need = 0.
- eff = max(base, need). slip <= eff − base.
- If eff > 2^CNT_W−1: clamp to max and set ovf_err.
- tail_free: cycles from current cycle to the first bus-free cycle. On accept it is loaded with eff+B−1. Otherwise it decrements each cycle, saturating at 0. last_dir is updated on accept.
- Timing: first data clock is cycle t+eff. rw_rdy pulses then. data_valid is high for cycles t+eff .. t+eff+B−1. rw_done pulses at t+eff+B.
- All entry countdowns decrement every cycle. The head entry is popped on the cycle its burst starts. Bursts never overlap: they start strictly in CAS order.
- FSM: IDLE (queue empty, no burst) → WAIT on accept; WAIT → DATA when head countdown hits 0; DATA holds B cycles; then → WAIT if queue non-empty, → DATA directly if the next head starts the very next cycle, else → IDLE.
- Full: cas_full = (count==DEPTH). cas_rdy while full is dropped and sets ovf_err, unless the head pops the same cycle; then the push is accepted and count is unchanged.
- Simultaneous accept and pop when not full: both occur; count unchanged.
- rw_dir/rw_tag hold the active burst's values during DATA. They hold the last values otherwise.

Test Plan:
- rd_delay=11, single READ CAS at cycle 0, BL8 → rw_rdy at 11, data_valid 11–14, rw_done 15, slip=0, data_idle returns to 1 at 15.
- READs at cycles 0 and 2 (rd_delay=11) → second burst rw_rdy at 15, slip=2. READs at 0 and 4 → second at 15, slip=0, data_valid continuous 11–18, no rw_done gap at 15.
- READ at 0 (rd=11), WRITE at 4 (wr_delay=9, TURN=2) → write rw_rdy at 17, slip=4, rw_dir=1, tag matches.
- BC4 READ at 0, BL8 READ at 2 (rd=11) → data_valid 11–12 then 13–16, rw_done pulses at 13 and 17.
- DEPTH=8: 9 CAS pulses, no pops → cas_full after 8th, 9th dropped, ovf_err=1 and sticky; a CAS on the same cycle as a head pop while full is accepted.
- Reset asserted at cycle 12 of a single read burst → all outputs return to reset values asynchronously. A new CAS after release schedules with slip=0.
